// File: rtl/wave_capture_buffer.sv
// Captures one window of the audio stream, starting at a rising zero crossing,
// into the write half of a ping-pong display RAM, then swaps halves once the display is idle.
module wave_capture_buffer #(
   parameter int ADDR_WIDTH  = 8,
   parameter int SAMPLE_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  new_sample_ready,
   input  logic [15:0]           new_sample_in,
   input  logic                  wave_display_idle,
   output logic [ADDR_WIDTH:0]   write_address,
   output logic                  write_enable,
   output logic [SAMPLE_BITS-1:0] write_sample,
   output logic                  read_index,
   output logic                  capture_done
);

   localparam logic [1:0] ST_ARMED  = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;

   localparam logic [ADDR_WIDTH-1:0] COUNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] COUNT_LAST = {ADDR_WIDTH{1'b1}};

   logic [1:0]             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  count_q, count_d;
   logic                   prev_neg_q, prev_neg_d;
   logic                   read_index_q, read_index_d;
   logic                   write_enable_q, write_enable_d;
   logic [ADDR_WIDTH:0]    write_address_q, write_address_d;
   logic [SAMPLE_BITS-1:0] write_sample_q, write_sample_d;
   logic                   capture_done_q, capture_done_d;

   // Signed to offset binary: flip the sign bit and keep the top magnitude bits.
   logic [SAMPLE_BITS-1:0] mapped_sample;
   assign mapped_sample = {~new_sample_in[15], new_sample_in[14:16-SAMPLE_BITS]};

   always_comb begin
      state_d         = state_q;
      count_d         = count_q;
      prev_neg_d      = prev_neg_q;
      read_index_d    = read_index_q;
      write_enable_d  = 1'b0;
      write_address_d = write_address_q;
      write_sample_d  = write_sample_q;
      capture_done_d  = 1'b0;

      if (new_sample_ready) begin
         prev_neg_d = new_sample_in[15];
      end

      case (state_q)
         ST_ARMED: begin
            if (new_sample_ready && prev_neg_q && !new_sample_in[15]) begin
               write_enable_d  = 1'b1;
               write_address_d = {~read_index_q, {ADDR_WIDTH{1'b0}}};
               write_sample_d  = mapped_sample;
               count_d         = COUNT_ONE;
               state_d         = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (new_sample_ready) begin
               write_enable_d  = 1'b1;
               write_address_d = {~read_index_q, count_q};
               write_sample_d  = mapped_sample;
               count_d         = count_q + COUNT_ONE;
               if (count_q == COUNT_LAST) begin
                  capture_done_d = 1'b1;
                  state_d        = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            // Swap only while the display is between frames so it never sees its half change.
            if (wave_display_idle) begin
               read_index_d = ~read_index_q;
               state_d      = ST_ARMED;
            end
         end
         default: begin
            state_d = ST_ARMED;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_ARMED;
         count_q         <= '0;
         prev_neg_q      <= 1'b0;
         read_index_q    <= 1'b0;
         write_enable_q  <= 1'b0;
         write_address_q <= '0;
         write_sample_q  <= '0;
         capture_done_q  <= 1'b0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         prev_neg_q      <= prev_neg_d;
         read_index_q    <= read_index_d;
         write_enable_q  <= write_enable_d;
         write_address_q <= write_address_d;
         write_sample_q  <= write_sample_d;
         capture_done_q  <= capture_done_d;
      end
   end

   assign write_address = write_address_q;
   assign write_enable  = write_enable_q;
   assign write_sample  = write_sample_q;
   assign read_index    = read_index_q;
   assign capture_done  = capture_done_q;

endmodule

// File: doc/wave_capture_buffer.md
Name: wave_capture_buffer

Overview:
- Consumer of the music player's output sample stream (`new_sample_generated` / `sample_out`).
- Waits for a negative-to-non-negative zero crossing, then captures a fixed-length window of samples into one half of a ping-pong display RAM.
- After a window completes, it waits for the wave display to go idle, then swaps buffer halves and re-arms.
- Sits between `music_player` and the display RAM write port.

Parameters:
- ADDR_WIDTH, 8, log2 of samples per capture window (window = 2^ADDR_WIDTH = 256 samples).
- SAMPLE_BITS, 8, width of the sample written to RAM (upper bits of the 16-bit input).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- new_sample_ready  input  1  one-cycle pulse: `new_sample_in` is valid (driven from `new_sample_generated`).
- new_sample_in  input  16  signed two's-complement audio sample (driven from `sample_out`).
- wave_display_idle  input  1  high while the display is not reading the RAM (between frames).
- write_address  output  ADDR_WIDTH+1  RAM write address = {write buffer half, sample index}.
- write_enable  output  1  one-cycle RAM write strobe.
- write_sample  output  SAMPLE_BITS  offset-binary sample written to RAM.
- read_index  output  1  buffer half the display reads; the write half is ~read_index.
- capture_done  output  1  one-cycle pulse when a window completes.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high, with clock `clk` and reset `reset`.
- Reset values:
  - state = ARMED, count = 0, prev_neg = 0, read_index = 0.
  - write_enable = 0, write_address = 0, write_sample = 0, capture_done = 0.
- prev_neg register: loaded with `new_sample_in[15]` on every `new_sample_ready`, in every state.
- Trigger: state = ARMED AND `new_sample_ready` AND prev_neg = 1 AND `new_sample_in[15]` = 0.
- ARMED:
  - No writes except the trigger sample.
  - On trigger, the triggering sample is written at index 0, count becomes 1, next state = ACTIVE.
  - A sample of exactly 0 counts as non-negative.
- ACTIVE:
  - Each `new_sample_ready` writes the sample at index `count`, then count increments.
  - The write at index 2^ADDR_WIDTH-1 moves the block to WAIT and count wraps to 0.
  - Cycles without `new_sample_ready` hold state.
  - Zero crossings are ignored.
- WAIT:
  - `new_sample_ready` produces no write; prev_neg still updates.
  - When `wave_display_idle` = 1: read_index toggles and next state = ARMED.
  - The transition takes one cycle. A sample arriving in that same cycle can only update prev_neg; it cannot trigger.
- Write pipeline: registered, latency 1. A sample accepted at edge N produces all of the following in the cycle after edge N, for exactly one cycle:
  - write_enable = 1
  - write_address = {~read_index, index}, using read_index as it was when the sample was accepted
  - write_sample = {~new_sample_in[15], new_sample_in[14:16-SAMPLE_BITS]}
- write_address and write_sample hold their last values when write_enable = 0.
- Sample mapping: the offset-binary mapping gives -32768 -> 0x00, 0 -> 0x80, +32767 -> 0xFF.
- capture_done: asserted in the same cycle as the write_enable of the final sample (index 255).
- read_index changes only on WAIT->ARMED, so the display never sees its half written.
- Back-to-back samples on consecutive cycles must be accepted; each produces its own write.
- Reset mid-capture: the partial window is abandoned, read_index returns to 0, and no write_enable occurs after reset asserts.
- The FSM has 3 states; illegal encodings recover to ARMED on the next clock.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> all outputs 0 immediately; state ARMED, read_index = 0.
- Trigger: samples -5, +3 -> one cycle after +3: write_enable = 1, write_address = 0x100, write_sample = 0x80. Samples +3, +7 (no crossing) -> no write.
- Full window: trigger, then 255 more samples 0x0100..0x01FE -> addresses 0x100..0x1FF written in order. capture_done pulses with the 0x1FF write. State WAIT; further samples produce no writes.
- Swap: in WAIT, hold `wave_display_idle` = 0 for 1000 cycles -> read_index stays 0. Raise it -> read_index = 1. Next trigger writes address 0x000.
- Edge cases:
  - -1 then 0 -> triggers, write_sample = 0x80.
  - -32768 written as 0x00; +32767 written as 0xFF.
  - A crossing presented in the same cycle as WAIT->ARMED -> no trigger.
- Reset mid-capture: reset after 100 writes -> no further writes. Next crossing restarts at index 0 with read_index = 0 (address 0x100).
